// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order decoupling FIFO between decode/rename and the
// reservation stations. Accepts up to IN_W entries per cycle, dispatches up
// to OUT_W per cycle to NUM_FXU FXU ports, one LSU port and one branch port,
// assigns sequential ROB tags, and handles sticky halt and flush.
// Optional: define DQ_PERF_CNT_EN to add saturating performance counters.
module dispatch_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned IN_W      = 4,
    parameter int unsigned OUT_W     = 4,
    parameter int unsigned NUM_FXU   = 2,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [$clog2(IN_W+1)-1:0]       in_count,
    input  logic [2*IN_W-1:0]               in_class_flat,
    input  logic [PAYLOAD_W*IN_W-1:0]       in_payload_flat,
    output logic                            in_ready,
    output logic [$clog2(DEPTH+1)-1:0]      free_slots,
    input  logic [NUM_FXU-1:0]              fxu_full,
    input  logic                            lsu_full,
    input  logic                            br_full,
    input  logic [TAG_W:0]                  rob_free,
    output logic [NUM_FXU-1:0]              fxu_valid,
    output logic [PAYLOAD_W*NUM_FXU-1:0]    fxu_payload_flat,
    output logic [TAG_W*NUM_FXU-1:0]        fxu_tag_flat,
    output logic                            lsu_valid,
    output logic [PAYLOAD_W-1:0]            lsu_payload,
    output logic [TAG_W-1:0]                lsu_tag,
    output logic                            br_valid,
    output logic [PAYLOAD_W-1:0]            br_payload,
    output logic [TAG_W-1:0]                br_tag,
    output logic [$clog2(OUT_W+1)-1:0]      rob_alloc_count,
    output logic                            rob_alloc_halt,
    output logic                            halted,
    input  logic                            flush,
    input  logic [TAG_W-1:0]                flush_tag
`ifdef DQ_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_stall_cycles,
    output logic [31:0]                     perf_dispatched,
    output logic [31:0]                     perf_full_cycles
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned INC_W  = $clog2(IN_W + 1);
    localparam int unsigned OUTC_W = $clog2(OUT_W + 1);

    localparam logic [1:0] CLS_FXU = 2'd0;
    localparam logic [1:0] CLS_LSU = 2'd1;
    localparam logic [1:0] CLS_BR  = 2'd2;

    logic [1:0]           cls_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              halted_q, halted_d;

    logic              enq_fire;
    logic [INC_W-1:0]  enq_n;
    logic [OUTC_W-1:0] disp_n;
    logic              disp_halt;

    logic [NUM_FXU-1:0] fxu_used;
    logic               lsu_used, br_used;
    logic               stop, placed, last;
    logic [PTR_W-1:0]   idx;
    logic [TAG_W-1:0]   slot_tag;

    // Credit is based on the registered occupancy only
    assign in_ready   = (32'(DEPTH) - 32'(count_q)) >= IN_W;
    assign free_slots = CNT_W'(DEPTH) - count_q;

    assign rob_alloc_count = disp_n;
    assign rob_alloc_halt  = disp_halt;
    assign halted          = halted_q;

    // Enqueue acceptance and lane count (oversized counts clamp to IN_W)
    always_comb begin
        enq_fire = in_valid & in_ready & ~flush;
        enq_n    = '0;
        if (enq_fire) begin
            enq_n = (32'(in_count) > IN_W) ? INC_W'(IN_W) : in_count;
        end
    end

    // In-order head-window scan: allocate ports, stop at first blocked entry or halt
    always_comb begin
        fxu_valid        = '0;
        fxu_payload_flat = '0;
        fxu_tag_flat     = '0;
        lsu_valid        = 1'b0;
        lsu_payload      = '0;
        lsu_tag          = '0;
        br_valid         = 1'b0;
        br_payload       = '0;
        br_tag           = '0;
        disp_n           = '0;
        disp_halt        = 1'b0;
        fxu_used         = '0;
        lsu_used         = 1'b0;
        br_used          = 1'b0;
        stop             = flush | halted_q;
        placed           = 1'b0;
        last             = 1'b0;
        idx              = '0;
        slot_tag         = '0;
        for (int unsigned k = 0; k < OUT_W; k++) begin
            idx      = head_q + PTR_W'(k);
            slot_tag = tag_q + TAG_W'(k);
            placed   = 1'b0;
            last     = 1'b0;
            if (!stop && (32'(count_q) > k) && (32'(rob_free) > k)) begin
                case (cls_q[idx])
                    CLS_FXU: begin
                        for (int unsigned j = 0; j < NUM_FXU; j++) begin
                            if (!placed && !fxu_full[j] && !fxu_used[j]) begin
                                placed      = 1'b1;
                                fxu_used[j] = 1'b1;
                                fxu_valid[j] = 1'b1;
                                fxu_payload_flat[PAYLOAD_W*j +: PAYLOAD_W] = pay_q[idx];
                                fxu_tag_flat[TAG_W*j +: TAG_W] = slot_tag;
                            end
                        end
                    end
                    CLS_LSU: begin
                        if (!lsu_full && !lsu_used) begin
                            placed      = 1'b1;
                            lsu_used    = 1'b1;
                            lsu_valid   = 1'b1;
                            lsu_payload = pay_q[idx];
                            lsu_tag     = slot_tag;
                        end
                    end
                    CLS_BR: begin
                        if (!br_full && !br_used) begin
                            placed     = 1'b1;
                            br_used    = 1'b1;
                            br_valid   = 1'b1;
                            br_payload = pay_q[idx];
                            br_tag     = slot_tag;
                        end
                    end
                    default: begin
                        placed    = 1'b1;
                        last      = 1'b1;
                        disp_halt = 1'b1;
                    end
                endcase
            end
            if (placed) begin
                disp_n = disp_n + OUTC_W'(1);
            end
            if (!placed || last) begin
                stop = 1'b1;
            end
        end
    end

    // Pointer, occupancy, tag and halt next-state; flush overrides everything
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        tag_d    = tag_q;
        halted_d = halted_q;
        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            tag_d    = flush_tag;
            halted_d = 1'b0;
        end else begin
            head_d   = head_q + PTR_W'(disp_n);
            tail_d   = tail_q + PTR_W'(enq_n);
            count_d  = count_q + CNT_W'(enq_n) - CNT_W'(disp_n);
            tag_d    = tag_q + TAG_W'(disp_n);
            halted_d = halted_q | disp_halt;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            tag_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
            halted_q <= halted_d;
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (32'(enq_n) > i) begin
                cls_q[tail_q + PTR_W'(i)] <= in_class_flat[2*i +: 2];
                pay_q[tail_q + PTR_W'(i)] <= in_payload_flat[PAYLOAD_W*i +: PAYLOAD_W];
            end
        end
    end

`ifdef DQ_PERF_CNT_EN
    logic [31:0] stall_q, disp_q, full_q;
    logic [32:0] disp_sum;

    assign disp_sum          = {1'b0, disp_q} + 33'(disp_n);
    assign perf_stall_cycles = stall_q;
    assign perf_dispatched   = disp_q;
    assign perf_full_cycles  = full_q;

    // Saturating performance counters; only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            disp_q  <= '0;
            full_q  <= '0;
        end else begin
            if ((count_q != '0) && (disp_n == '0) && !halted_q && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            disp_q <= disp_sum[32] ? '1 : disp_sum[31:0];
            if ((count_q == CNT_W'(DEPTH)) && (full_q != '1)) begin
                full_q <= full_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_dispatch_queue;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned IN_W      = 4;
    localparam int unsigned OUT_W     = 4;
    localparam int unsigned NUM_FXU   = 2;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned TAG_W     = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [2:0]   in_count = '0;
    logic [7:0]   in_class_flat = '0;
    logic [127:0] in_payload_flat = '0;
    logic         in_ready;
    logic [3:0]   free_slots;
    logic [1:0]   fxu_full = '0;
    logic         lsu_full = 1'b0;
    logic         br_full = 1'b0;
    logic [4:0]   rob_free = 5'd16;
    logic [1:0]   fxu_valid;
    logic [63:0]  fxu_payload_flat;
    logic [7:0]   fxu_tag_flat;
    logic         lsu_valid;
    logic [31:0]  lsu_payload;
    logic [3:0]   lsu_tag;
    logic         br_valid;
    logic [31:0]  br_payload;
    logic [3:0]   br_tag;
    logic [2:0]   rob_alloc_count;
    logic         rob_alloc_halt;
    logic         halted;
    logic         flush = 1'b0;
    logic [3:0]   flush_tag = '0;
`ifdef DQ_PERF_CNT_EN
    logic [31:0]  perf_stall_cycles, perf_dispatched, perf_full_cycles;
`endif

    dispatch_queue #(
        .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W),
        .NUM_FXU(NUM_FXU), .PAYLOAD_W(PAYLOAD_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_count(in_count),
        .in_class_flat(in_class_flat), .in_payload_flat(in_payload_flat),
        .in_ready(in_ready), .free_slots(free_slots),
        .fxu_full(fxu_full), .lsu_full(lsu_full), .br_full(br_full),
        .rob_free(rob_free),
        .fxu_valid(fxu_valid), .fxu_payload_flat(fxu_payload_flat),
        .fxu_tag_flat(fxu_tag_flat),
        .lsu_valid(lsu_valid), .lsu_payload(lsu_payload), .lsu_tag(lsu_tag),
        .br_valid(br_valid), .br_payload(br_payload), .br_tag(br_tag),
        .rob_alloc_count(rob_alloc_count), .rob_alloc_halt(rob_alloc_halt),
        .halted(halted), .flush(flush), .flush_tag(flush_tag)
`ifdef DQ_PERF_CNT_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_dispatched(perf_dispatched),
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cls;
        logic [31:0] pay;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_tag;
    bit          m_halted;
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  e_fxu_valid;
    logic [63:0] e_fxu_pay;
    logic [7:0]  e_fxu_tag;
    logic        e_lsu_valid, e_br_valid, e_halt;
    logic [31:0] e_lsu_pay, e_br_pay;
    logic [3:0]  e_lsu_tag, e_br_tag;
    int          e_n;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected dispatch group from model contents and current port state
    task automatic model_dispatch();
        bit used[NUM_FXU];
        bit lsu_u, br_u, ok, last;
        int port;
        logic [3:0] t;
        e_fxu_valid = '0; e_fxu_pay = '0; e_fxu_tag = '0;
        e_lsu_valid = 0; e_lsu_pay = '0; e_lsu_tag = '0;
        e_br_valid = 0; e_br_pay = '0; e_br_tag = '0;
        e_halt = 0; e_n = 0; lsu_u = 0; br_u = 0;
        for (int j = 0; j < NUM_FXU; j++) used[j] = 0;
        if (flush || m_halted) return;
        for (int k = 0; k < OUT_W; k++) begin
            if (k >= mq.size() || k >= int'(rob_free)) break;
            t = 4'((m_tag + k) % 16);
            ok = 0; last = 0;
            case (mq[k].cls)
                2'd0: begin
                    port = -1;
                    for (int j = 0; j < NUM_FXU; j++)
                        if (port < 0 && !fxu_full[j] && !used[j]) port = j;
                    if (port >= 0) begin
                        used[port] = 1; ok = 1;
                        e_fxu_valid[port] = 1'b1;
                        e_fxu_pay[32*port +: 32] = mq[k].pay;
                        e_fxu_tag[4*port +: 4] = t;
                    end
                end
                2'd1: if (!lsu_full && !lsu_u) begin
                    lsu_u = 1; ok = 1; e_lsu_valid = 1; e_lsu_pay = mq[k].pay; e_lsu_tag = t;
                end
                2'd2: if (!br_full && !br_u) begin
                    br_u = 1; ok = 1; e_br_valid = 1; e_br_pay = mq[k].pay; e_br_tag = t;
                end
                default: begin ok = 1; last = 1; e_halt = 1; end
            endcase
            if (!ok) break;
            e_n++;
            if (last) break;
        end
    endtask

    // Advance the model across one clock edge
    task automatic model_update();
        bit enq_ok;
        enq_ok = in_valid && ((DEPTH - mq.size()) >= IN_W);
        if (flush) begin
            mq.delete();
            m_tag = int'(flush_tag);
            m_halted = 0;
        end else begin
            for (int i = 0; i < e_n; i++) void'(mq.pop_front());
            m_tag = (m_tag + e_n) % 16;
            if (e_halt) m_halted = 1;
            if (enq_ok)
                for (int i = 0; i < int'(in_count); i++)
                    mq.push_back('{cls: in_class_flat[2*i +: 2], pay: in_payload_flat[32*i +: 32]});
        end
    endtask

    task automatic check_outputs();
        check("fxu_valid", 128'(fxu_valid), 128'(e_fxu_valid));
        check("fxu_payload", 128'(fxu_payload_flat), 128'(e_fxu_pay));
        check("fxu_tag", 128'(fxu_tag_flat), 128'(e_fxu_tag));
        check("lsu_valid", 128'(lsu_valid), 128'(e_lsu_valid));
        check("lsu_payload", 128'(lsu_payload), 128'(e_lsu_pay));
        check("lsu_tag", 128'(lsu_tag), 128'(e_lsu_tag));
        check("br_valid", 128'(br_valid), 128'(e_br_valid));
        check("br_payload", 128'(br_payload), 128'(e_br_pay));
        check("br_tag", 128'(br_tag), 128'(e_br_tag));
        check("rob_alloc_count", 128'(rob_alloc_count), 128'(e_n));
        check("rob_alloc_halt", 128'(rob_alloc_halt), 128'(e_halt));
        check("halted", 128'(halted), 128'(m_halted));
        check("free_slots", 128'(free_slots), 128'(DEPTH - mq.size()));
        check("in_ready", 128'(in_ready), 128'((DEPTH - mq.size()) >= IN_W));
    endtask

    task automatic eval();
        #2;
        model_dispatch();
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic enq(input int cnt, input logic [7:0] cls, input logic [127:0] pay);
        in_valid = 1'b1; in_count = 3'(cnt); in_class_flat = cls; in_payload_flat = pay;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_count = '0;
    endtask

    initial begin
        m_tag = 0; m_halted = 0;
        #3;
        model_dispatch();
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Four FXU entries, two per cycle in order
        enq(4, 8'h00, {32'h14, 32'h13, 32'h12, 32'h11});
        eval(); tick();
        idle();
        eval();
        check("tp1_pay0", 128'(fxu_payload_flat), 128'(64'h00000012_00000011));
        check("tp1_tag0", 128'(fxu_tag_flat), 128'(8'h10));
        tick();
        eval();
        check("tp1_pay1", 128'(fxu_payload_flat), 128'(64'h00000014_00000013));
        check("tp1_tag1", 128'(fxu_tag_flat), 128'(8'h32));
        tick();

        // Mixed classes with FXU port 0 blocked
        enq(4, {2'd0, 2'd2, 2'd1, 2'd0}, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
        fxu_full = 2'b01;
        eval(); tick();
        idle();
        eval();
        check("tp2_fxu_valid", 128'(fxu_valid), 128'(2'b10));
        check("tp2_alloc", 128'(rob_alloc_count), 128'(3));
        tick();
        fxu_full = 2'b00;
        eval(); tick();

        // Fill to DEPTH with FXUs blocked, then drain
        fxu_full = 2'b11;
        enq(4, 8'h00, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
        eval(); tick();
        enq(4, 8'h00, {32'hB8, 32'hB7, 32'hB6, 32'hB5});
        eval(); tick();
        idle();
        eval();
        check("tp3_free", 128'(free_slots), 128'(0));
        check("tp3_ready", 128'(in_ready), 128'(0));
        tick();
        fxu_full = 2'b00;
        for (int i = 0; i < 5; i++) begin eval(); tick(); end

        // Tag wrap after flush to 14
        flush = 1'b1; flush_tag = 4'd14;
        eval(); tick();
        flush = 1'b0;
        enq(4, 8'h00, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
        eval(); tick();
        idle();
        eval();
        check("tp4_tag0", 128'(fxu_tag_flat), 128'(8'hFE));
        tick();
        eval();
        check("tp4_tag1", 128'(fxu_tag_flat), 128'(8'h10));
        tick();

        // Halt terminates group and sticks until flush
        enq(3, {2'd0, 2'd0, 2'd3, 2'd0}, {32'h0, 32'hD3, 32'hD2, 32'hD1});
        eval(); tick();
        idle();
        eval();
        check("tp5_halt", 128'(rob_alloc_halt), 128'(1));
        check("tp5_alloc", 128'(rob_alloc_count), 128'(2));
        tick();
        for (int i = 0; i < 2; i++) begin
            eval();
            check("tp5_halted", 128'(halted), 128'(1));
            check("tp5_stuck", 128'(fxu_valid), 128'(0));
            tick();
        end
        flush = 1'b1;
        eval(); tick();
        flush = 1'b0;
        eval();
        check("tp5_unhalt", 128'(halted), 128'(0));
        check("tp5_empty", 128'(free_slots), 128'(DEPTH));
        tick();

        // ROB credit of one limits the group; reset mid-stream
        rob_free = 5'd1;
        enq(3, 8'h00, {32'h0, 32'hE3, 32'hE2, 32'hE1});
        eval(); tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            eval();
            check("tp6_one", 128'(rob_alloc_count), 128'(1));
            tick();
        end
        rst_n = 1'b0;
        #1;
        mq.delete(); m_tag = 0; m_halted = 0;
        model_dispatch();
        check_outputs();
        check("tp6_rst_valid", 128'(fxu_valid), 128'(0));
        check("tp6_rst_free", 128'(free_slots), 128'(DEPTH));
        @(posedge clk); #1;
        rst_n = 1'b1;
        rob_free = 5'd16;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom % 4) != 0;
            in_count = 3'($urandom_range(0, IN_W));
            for (int l = 0; l < IN_W; l++) begin
                int r;
                r = int'($urandom % 24);
                in_class_flat[2*l +: 2] = (r == 0) ? 2'd3 : 2'(r % 3);
                in_payload_flat[32*l +: 32] = $urandom;
            end
            fxu_full  = 2'($urandom & $urandom);
            lsu_full  = ($urandom % 4) == 0;
            br_full   = ($urandom % 4) == 0;
            rob_free  = (($urandom % 4) == 0) ? 5'($urandom_range(0, 3)) : 5'd16;
            flush     = ($urandom % 20) == 0;
            flush_tag = 4'($urandom);
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor to the fixed 4-wide instruction buffer.
- Decoupling FIFO between decode/rename and the reservation stations. It accepts up to IN_W decoded instructions per cycle and dispatches up to OUT_W per cycle, strictly in program order, to NUM_FXU FXU ports, one LSU port and one branch port.
- It owns ROB tag assignment (sequential, wrapping), sticky halt and pipeline flush.

Parameters:
- DEPTH, 8: queue entries; power of 2, DEPTH >= IN_W.
- IN_W, 4: max enqueue lanes per cycle.
- OUT_W, 4: max dispatches per cycle (head window size).
- NUM_FXU, 2: number of FXU dispatch ports.
- PAYLOAD_W, 32: opaque per-instruction payload (opcode, imm, operand owner info).
- TAG_W, 4: ROB tag width; tags wrap mod 2^TAG_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  enqueue request
- in_count  in  $clog2(IN_W+1)  number of valid lanes (lanes 0..in_count-1)
- in_class_flat  in  2*IN_W  per-lane class: 0=FXU, 1=LSU, 2=branch, 3=halt
- in_payload_flat  in  PAYLOAD_W*IN_W  per-lane payload
- in_ready  out  1  free slots >= IN_W
- free_slots  out  $clog2(DEPTH+1)  DEPTH minus occupancy
- fxu_full  in  NUM_FXU  per-FXU port full
- lsu_full  in  1  LSU full
- br_full  in  1  branch unit full
- rob_free  in  TAG_W+1  free ROB entries
- fxu_valid  out  NUM_FXU  dispatch strobe per FXU port
- fxu_payload_flat  out  PAYLOAD_W*NUM_FXU  payload per FXU port
- fxu_tag_flat  out  TAG_W*NUM_FXU  tag per FXU port
- lsu_valid / lsu_payload / lsu_tag  out  1 / PAYLOAD_W / TAG_W  LSU dispatch
- br_valid / br_payload / br_tag  out  1 / PAYLOAD_W / TAG_W  branch dispatch
- rob_alloc_count  out  $clog2(OUT_W+1)  entries dispatched this cycle
- rob_alloc_halt  out  1  a halt entry is in this cycle's dispatch group
- halted  out  1  sticky halt state
- flush  in  1  synchronous flush
- flush_tag  in  TAG_W  next tag after flush

Behaviour:
- Lane 0 is the oldest lane and occupies the LSBs of every flat vector.
- State:
  - circular array of {class, payload}
  - head and tail pointers, log2(DEPTH) bits, wrap naturally
  - count, 0..DEPTH
  - next_tag
  - halted
- Reset (async, rst_n low): head=tail=count=0, next_tag=0, halted=0. Outputs: all *_valid=0, rob_alloc_count=0, rob_alloc_halt=0, free_slots=DEPTH, in_ready=1.
- Enqueue:
  - Fires when in_valid & in_ready & ~flush.
  - Writes lanes 0..in_count-1 at tail..tail+in_count-1 (mod DEPTH); tail += in_count.
  - in_count=0 is a no-op.
  - in_ready uses the registered count only (no same-cycle credit from dequeue). There is no combinational path from in_* to any output.
- Dispatch is combinational from registered state plus the full/rob_free inputs. Scan head window k = 0..OUT_W-1. Entry k dispatches iff all of:
  - entries 0..k-1 dispatched
  - k < count
  - halted=0
  - no earlier halt in the group
  - k < rob_free
  - a port of its class is available
- Port availability:
  - FXU: lowest-index FXU port with fxu_full=0 that is not already used this cycle.
  - LSU and branch: at most one per cycle each, gated by lsu_full / br_full.
  - Halt: needs no port. It dispatches (counts in rob_alloc_count, asserts rob_alloc_halt) and terminates the group.
- First non-dispatchable entry stops the scan (in-order stall).
- Tags: dispatched entry k gets (next_tag + k) mod 2^TAG_W.
- Clock edge: head += n, count += enq − n, next_tag += n, where n = rob_alloc_count. halted is set if rob_alloc_halt.
- halted stays set until flush or reset. While halted, the queue keeps accepting entries until full.
- Flush:
  - Highest priority over enqueue and dispatch.
  - In the flush cycle, all *_valid and rob_alloc_count are forced to 0.
  - Next cycle: count=0, head=tail=0, next_tag=flush_tag, halted=0.
- Unused output ports drive payload/tag = 0.
- Simultaneous enqueue and dispatch at count=DEPTH-1 or count=0: both apply; count stays within 0..DEPTH.
- Dispatch never reads entries enqueued in the same cycle (one-cycle minimum latency in to out).

Optional Feature:
- Macro: DQ_PERF_CNT_EN.
- When defined, adds three 32-bit saturating counters, reset to 0 and cleared by neither flush nor halt:
  - perf_stall_cycles: count>0, n=0, not halted.
  - perf_dispatched: += n.
  - perf_full_cycles: count=DEPTH.
- Exported as outputs perf_stall_cycles, perf_dispatched, perf_full_cycles.
- When undefined, these ports and counters are absent.

Test Plan:
- Reset, then enqueue 4 FXU entries (payloads 0x11..0x14), all fulls=0, rob_free=16 -> next cycle fxu_valid=2'b11 with payloads 0x11/0x12 and tags 0/1; following cycle 0x13/0x14 with tags 2/3.
- Enqueue FXU,LSU,BR,FXU with NUM_FXU=2, fxu_full=2'b01 -> fxu_valid=2'b10 (entry0), lsu_valid, br_valid, entry3 stalls; rob_alloc_count=3.
- Fill 8 entries, fxu_full=2'b11 -> free_slots=0, in_ready=0; release -> in_ready=1 only after count<=4.
- Set next_tag to 14 via flush_tag=14, then dispatch 4 entries -> tags 14,15,0,1.
- Enqueue FXU,HALT,FXU -> group = FXU + halt, rob_alloc_halt=1, halted=1, third entry never dispatches; flush -> halted=0, count=0.
- rob_free=1 with 3 dispatchable entries -> exactly 1 dispatched per cycle; assert rst_n low mid-stream -> all outputs at reset values immediately.
